// File: rtl/icebreaker_pkg.sv
// Shared types and default timing constants for the iCEBreaker button logic.
// Defaults assume the 12 MHz board clock.
package icebreaker_pkg;

  localparam int DebounceCycles  = 120_000;
  localparam int LongPressCycles = 12_000_000;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } debounce_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops load RstVal while rst is high.
module sync2 #(
  parameter logic RstVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RstVal;
      sync_q <= RstVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces an active-low button; emits press, release and long-press pulses.
// All outputs are registered and derived from the next-state logic.
module button_debouncer #(
  parameter int DebounceCycles  = icebreaker_pkg::DebounceCycles,
  parameter int LongPressCycles = icebreaker_pkg::LongPressCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  import icebreaker_pkg::*;

  if (DebounceCycles < 2) begin : g_bad_db
    $error("DebounceCycles must be >= 2");
  end
  if (LongPressCycles < 2) begin : g_bad_lp
    $error("LongPressCycles must be >= 2");
  end

  localparam int DW = $clog2(DebounceCycles);
  localparam int LW = $clog2(LongPressCycles);
  localparam logic [DW-1:0] DMax = DW'(DebounceCycles - 1);
  localparam logic [LW-1:0] LMax = LW'(LongPressCycles - 1);

  logic btn_sync;
  logic s;

  sync2 #(.RstVal(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_n_i),
    .q_o (btn_sync)
  );

  assign s = ~btn_sync;

  debounce_state_e state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   hold_q, hold_d;
  logic            done_q, done_d;
  logic            pressed_q, pressed_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      hold_q    <= '0;
      done_q    <= 1'b0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    done_d    = done_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_PENDING;
          cnt_d   = '0;
        end
      end
      PRESS_PENDING: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DMax) begin
          state_d = PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
          done_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      PRESSED: begin
        // Hold count saturates at LMax; done_q keeps the pulse to one per press.
        if (!s) begin
          state_d = RELEASE_PENDING;
          cnt_d   = '0;
        end else if (hold_q == LMax) begin
          if (!done_q) begin
            long_d = 1'b1;
            done_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + LW'(1);
        end
      end
      RELEASE_PENDING: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DMax) begin
          state_d   = RELEASED;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
    pressed_d = (state_d == PRESSED) ||
                (state_d == RELEASE_PENDING);
  end

  assign pressed_o    = pressed_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DebounceCycles=4, LongPressCycles=10.
// Expected edge numbers are hand-derived from the sync + debounce latency.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic btn_n_i;
  logic pressed_o;
  logic press_o;
  logic release_o;
  logic long_press_o;

  int checks = 0;
  int errs   = 0;

  button_debouncer #(
    .DebounceCycles (4),
    .LongPressCycles(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n_i     (btn_n_i),
    .pressed_o   (pressed_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .long_press_o(long_press_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int k,
                         input logic e_pd, input logic e_pr,
                         input logic e_rl, input logic e_lp);
    chk($sformatf("%s_pressed_%0d", tag, k), 32'(pressed_o), 32'(e_pd));
    chk($sformatf("%s_press_%0d", tag, k), 32'(press_o), 32'(e_pr));
    chk($sformatf("%s_release_%0d", tag, k), 32'(release_o), 32'(e_rl));
    chk($sformatf("%s_long_%0d", tag, k), 32'(long_press_o), 32'(e_lp));
  endtask

  logic [4:0] bounce;

  initial begin
    rst     = 1'b1;
    btn_n_i = 1'b0;

    // Reset with button held low: outputs stay 0.
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk_all("rst", k, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Held press from reset release: press after edge 7, long after 17.
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk_all("hold", k, k >= 7, k == 7, 1'b0, k == 17);
    end

    // Release: release_o and pressed_o fall after edge 7.
    btn_n_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("rel", k, k < 7, 1'b0, k == 7, 1'b0);
    end

    // Bounce: low 2, high 1, low 2, then high.
    bounce = 5'b00100;
    for (int k = 1; k <= 15; k++) begin
      btn_n_i = (k <= 5) ? bounce[5-k] : 1'b1;
      tick();
      chk_all("bnc", k, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Second press, then reset while in PRESSED.
    btn_n_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk_all("p2", k, k >= 7, k == 7, 1'b0, 1'b0);
    end
    rst = 1'b1;
    tick();
    chk_all("rstp", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst     = 1'b0;
    btn_n_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("post", k, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
